// File: rtl/alu_shift_sequencer_if.sv
// Request/ALU-feedback bundle for alu_shift_sequencer.
// The slave modport is the sequencer; the master modport is the control unit plus the ALU.
interface alu_shift_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
);
  logic              Start;
  logic [2:0]        Op;
  logic [DATA_W-1:0] Data;
  logic [CNT_W-1:0]  Amount;
  logic [DATA_W-1:0] ALUOut;
  logic [DATA_W-1:0] ALU_A;
  logic [4:0]        ALU_FunSel;
  logic              ALU_WF;
  logic              Busy;
  logic              Done;
  logic              Err;
  logic [DATA_W-1:0] Result;

  modport master (
    output Start, Op, Data, Amount, ALUOut,
    input  ALU_A, ALU_FunSel, ALU_WF, Busy, Done, Err, Result
  );
  modport slave (
    input  Start, Op, Data, Amount, ALUOut,
    output ALU_A, ALU_FunSel, ALU_WF, Busy, Done, Err, Result
  );
endinterface

// File: rtl/alu_shift_sequencer.sv
// Breaks a "shift by N" request into N single-bit ALU shift steps, feeding ALUOut back each cycle.
// Optional SHIFT_SEQ_EARLY_EXIT_EN: LSL/LSR stop as soon as the working value reaches zero.
module alu_shift_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic                 Clock,
  input  logic                 Reset,
  alu_shift_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] OP_LSL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_CSL = 3'd3;
  localparam logic [2:0] OP_CSR = 3'd4;
  localparam logic [4:0] FS_IDLE = 5'b1_0000;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              err_q, err_d;
  logic [3:0]        code;
  logic              last_step;

  always_comb begin
    code = 4'b1011;
    case (op_q)
      OP_LSL:  code = 4'b1011;
      OP_LSR:  code = 4'b1100;
      OP_ASR:  code = 4'b1101;
      OP_CSL:  code = 4'b1110;
      OP_CSR:  code = 4'b1111;
      default: code = 4'b1011;
    endcase
  end

  always_comb begin
    last_step = (cnt_q == CNT_W'(1));
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    // Zero stays zero under logical shifts, so the remaining steps cannot change Result.
    if ((op_q == OP_LSL || op_q == OP_LSR) && bus.ALUOut == '0)
      last_step = 1'b1;
`endif
  end

  always_comb begin
    state_d        = state_q;
    work_d         = work_q;
    result_d       = result_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    err_d          = 1'b0;
    bus.ALU_A      = '0;
    bus.ALU_FunSel = FS_IDLE;
    bus.ALU_WF     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          if (bus.Op <= OP_CSR) begin
            work_d = bus.Data;
            if (bus.Amount != '0) begin
              cnt_d   = bus.Amount;
              op_d    = bus.Op;
              state_d = SHIFT;
            end else begin
              // Result is loaded on entry to DONE so it is valid alongside the Done pulse.
              result_d = bus.Data;
              state_d  = DONE;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        bus.ALU_A      = work_q;
        bus.ALU_WF     = 1'b1;
        bus.ALU_FunSel = {1'b1, code};
        work_d         = bus.ALUOut;
        cnt_d          = cnt_q - CNT_W'(1);
        if (last_step) begin
          result_d = bus.ALUOut;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      work_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      err_q    <= err_d;
    end
  end

  assign bus.Busy   = (state_q == SHIFT);
  assign bus.Done   = (state_q == DONE);
  assign bus.Err    = err_q;
  assign bus.Result = result_q;
endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed plus random checks of alu_shift_sequencer against a closed-form shift/rotate model,
// with a single-bit-step ALU (including carry flag) closing the feedback loop.
module tb_alu_shift_sequencer;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] last_res = 32'h0;

  alu_shift_sequencer_if #(.DATA_W(32), .CNT_W(5)) sif ();

  alu_shift_sequencer #(.DATA_W(32), .CNT_W(5)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (sif.slave)
  );

  always #5 Clock = ~Clock;

  // Single-step ALU with carry flag; flags are never reset.
  logic        c_flag = 1'b0;
  logic        carry_n;
  logic [31:0] alu_out;
  always_comb begin
    carry_n = c_flag;
    alu_out = sif.ALU_A;
    case (sif.ALU_FunSel)
      5'b11011: begin alu_out = sif.ALU_A << 1;                     carry_n = sif.ALU_A[31]; end
      5'b11100: begin alu_out = sif.ALU_A >> 1;                     carry_n = sif.ALU_A[0];  end
      5'b11101: begin alu_out = {sif.ALU_A[31], sif.ALU_A[31:1]};   carry_n = sif.ALU_A[0];  end
      5'b11110: begin alu_out = {sif.ALU_A[30:0], c_flag};          carry_n = sif.ALU_A[31]; end
      5'b11111: begin alu_out = {c_flag, sif.ALU_A[31:1]};          carry_n = sif.ALU_A[0];  end
      default: ;
    endcase
  end
  assign sif.ALUOut = alu_out;
  always @(posedge Clock) if (sif.ALU_WF) c_flag <= carry_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] funsel_of(input logic [2:0] op);
    case (op)
      3'd0: return 5'b11011;
      3'd1: return 5'b11100;
      3'd2: return 5'b11101;
      3'd3: return 5'b11110;
      default: return 5'b11111;
    endcase
  endfunction

  // Closed-form reference: k steps of op on d with carry-in c0; returns {carry, value}.
  function automatic logic [32:0] ref_shift(input logic [2:0] op, input logic [31:0] d,
                                            input int k, input logic c0);
    logic [32:0] v, r;
    logic [31:0] t;
    t = d;
    v = {c0, d};
    if (k == 0) return {c0, d};
    case (op)
      3'd0: return {t[32-k], d << k};
      3'd1: return {t[k-1], d >> k};
      3'd2: return {t[k-1], 32'($signed(d) >>> k)};
      3'd3: begin r = (v << k) | (v >> (33 - k)); return r; end
      default: begin r = (v >> k) | (v << (33 - k)); return r; end
    endcase
  endfunction

  function automatic int model_steps(input logic [2:0] op, input logic [31:0] d, input int amt);
    int steps;
    steps = amt;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    if (op == 3'd0 || op == 3'd1)
      for (int k = 1; k <= amt; k++)
        if ((op == 3'd0 ? (d << k) : (d >> k)) == 32'h0) begin steps = k; break; end
`endif
    return steps;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] d, input int amt,
                        input int restart_at, input string tag);
    int steps, lat, busy_n, wf_n, bad_fs, errs;
    logic c0;
    logic [32:0] full, fstep;
    steps = model_steps(op, d, amt);
    @(negedge Clock);
    sif.Start = 1'b1; sif.Op = op; sif.Data = d; sif.Amount = 5'(amt);
    c0 = c_flag;
    full  = ref_shift(op, d, amt, c0);
    fstep = ref_shift(op, d, steps, c0);
    lat = 0; busy_n = 0; wf_n = 0; bad_fs = 0; errs = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge Clock);
      sif.Start = (cyc == restart_at);
      if (cyc == restart_at) begin sif.Op = 3'd0; sif.Data = 32'h1; sif.Amount = 5'd5; end
      if (sif.Done) begin lat = cyc; break; end
      if (sif.Busy) busy_n++;
      if (sif.ALU_WF) wf_n++;
      if (sif.Busy && sif.ALU_FunSel !== funsel_of(op)) bad_fs++;
      if (sif.Err) errs++;
    end
    sif.Start = 1'b0;
    chk({tag, "_latency"}, lat, (steps == 0) ? 1 : steps + 1);
    chk({tag, "_result"}, sif.Result, full[31:0]);
    chk({tag, "_busy_cycles"}, busy_n, steps);
    chk({tag, "_wf_cycles"}, wf_n, steps);
    chk({tag, "_funsel_bad"}, bad_fs, 0);
    chk({tag, "_err_seen"}, errs, 0);
    @(negedge Clock);
    chk({tag, "_done_once"}, {sif.Done, sif.Busy}, 2'b00);
    chk({tag, "_alu_idle"}, {sif.ALU_A, sif.ALU_FunSel, sif.ALU_WF}, {32'h0, 5'b10000, 1'b0});
    chk({tag, "_carry"}, c_flag, fstep[32]);
    chk({tag, "_result_held"}, sif.Result, full[31:0]);
    last_res = full[31:0];
  endtask

  initial begin
    sif.Start = 1'b0; sif.Op = 3'd0; sif.Data = 32'h0; sif.Amount = 5'd0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    chk("reset_status", {sif.Busy, sif.Done, sif.Err}, 3'b000);
    chk("reset_result", sif.Result, 32'h0);
    chk("reset_alu", {sif.ALU_A, sif.ALU_FunSel, sif.ALU_WF}, {32'h0, 5'b10000, 1'b0});

    run_op(3'd0, 32'h0000_0001, 4, 0, "lsl4");
    chk("lsl4_value", last_res, 32'h0000_0010);
    run_op(3'd2, 32'h8000_0000, 31, 0, "asr31");
    chk("asr31_value", last_res, 32'hFFFF_FFFF);
    run_op(3'd1, 32'hDEAD_BEEF, 0, 0, "lsr0");
    run_op(3'd1, 32'hF000_0000, 8, 3, "lsr8_restart");
    chk("lsr8_value", last_res, 32'h00F0_0000);

    // Reset on the 3rd SHIFT cycle of LSL by 10.
    @(negedge Clock);
    sif.Start = 1'b1; sif.Op = 3'd0; sif.Data = 32'h0000_0005; sif.Amount = 5'd10;
    @(negedge Clock); sif.Start = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    chk("mid_busy_before_reset", sif.Busy, 1'b1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("mid_reset_status", {sif.Busy, sif.Done}, 2'b00);
    chk("mid_reset_result", sif.Result, 32'h0);
    run_op(3'd0, 32'h0000_0003, 1, 0, "post_reset");
    chk("post_reset_value", last_res, 32'h0000_0006);

    // Illegal op.
    @(negedge Clock);
    sif.Start = 1'b1; sif.Op = 3'b101; sif.Data = 32'h1234_5678; sif.Amount = 5'd3;
    @(negedge Clock);
    sif.Start = 1'b0;
    chk("err_pulse", {sif.Err, sif.Busy}, 2'b10);
    chk("err_result", sif.Result, last_res);
    @(negedge Clock);
    chk("err_clear", {sif.Err, sif.Busy, sif.Done}, 3'b000);

    run_op(3'd1, 32'h0000_0002, 20, 0, "lsr20");
    run_op(3'd3, 32'h8000_0001, 1, 0, "csl1");
    run_op(3'd4, 32'h0000_0001, 31, 0, "csr31");

    for (int i = 0; i < 24; i++) begin
      logic [2:0] op;
      int amt;
      op  = 3'($urandom_range(0, 4));
      amt = (i % 6 == 0) ? 31 : ((i % 6 == 1) ? 0 : int'($urandom_range(1, 31)));
      run_op(op, $urandom, amt, 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
